// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
//
// Shared types and constants for the immediate-generator pipeline:
//   - imm_fmt_e   : immediate format code carried with every decoded entry
//   - OPC_*       : RV base opcodes recognised by the decoder
//   - imm_entry_t : one decoded entry {imm, fmt, sra, illegal}
//
// The entry always carries a 64-bit immediate so that the same struct can be
// used for either datapath width. A 32-bit build only uses the low half.
// ---------------------------------------------------------------------------
package imm_pkg;

    // Widest datapath supported. The immediate field of an entry is this wide.
    localparam int IMM_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    // funct3 values that turn an OP-IMM instruction into a shift.
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        imm_fmt_e         fmt;
        logic             sra;
        logic             illegal;
    } imm_entry_t;

    // Value of an empty entry; also what the outputs show out of reset.
    localparam imm_entry_t ENTRY_RESET = '{
        imm:     '0,
        fmt:     FMT_NONE,
        sra:     1'b0,
        illegal: 1'b0
    };

    // Sign-extend a 12-bit I/S-type field to the full entry width.
    function automatic logic [IMM_W-1:0] sext12(input logic [11:0] value);
        return {{(IMM_W-12){value[11]}}, value};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
//
// Purely combinational immediate decoder. The format is derived from the
// opcode field of the instruction; there is no external format select.
//
// Parameters:
//   XLEN  : datapath width, 32 or 64. Selects OP-IMM-32 support and the
//           width of the shift amount.
//
// Ports:
//   inst  : input  [31:0]  instruction word
//   entry : output         decoded {imm, fmt, sra, illegal}
//
// Configuration macro:
//   IMM_ILLEGAL_CHECK_EN : when defined, entry.illegal flags bad encodings
//                          (wrong low bits, unknown opcode, oversized shift
//                          amount on RV32, bad shift funct bits). When not
//                          defined, entry.illegal is always 0 and no check
//                          logic is built.
// ---------------------------------------------------------------------------
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] inst,
    output imm_entry_t  entry
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_op_imm;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // OP-IMM-32 only exists on a 64-bit datapath; on RV32 it falls through
    // to the unknown-opcode path below.
    assign is_op_imm = (opcode == OPC_OP_IMM) ||
                       ((XLEN == 64) && (opcode == OPC_OP_IMM_32));

    always_comb begin
        entry = ENTRY_RESET;

        if (is_op_imm) begin
            if ((funct3 == F3_SLL) || (funct3 == F3_SRX)) begin
                // Shift amounts are unsigned. Only a 64-bit OP-IMM shift
                // gets the sixth shamt bit; the 32-bit word forms do not.
                entry.fmt = FMT_SH;
                entry.sra = inst[30];
                if ((XLEN == 64) && (opcode == OPC_OP_IMM)) begin
                    entry.imm = {58'b0, inst[25:20]};
                end else begin
                    entry.imm = {59'b0, inst[24:20]};
                end
            end else begin
                entry.fmt = FMT_I;
                entry.imm = sext12(inst[31:20]);
            end
        end else begin
            case (opcode)
                OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                    entry.fmt = FMT_I;
                    entry.imm = sext12(inst[31:20]);
                end
                OPC_STORE: begin
                    entry.fmt = FMT_S;
                    entry.imm = sext12({inst[31:25], inst[11:7]});
                end
                OPC_BRANCH: begin
                    // Branch offsets are halfword aligned, so bit 0 is 0.
                    entry.fmt = FMT_B;
                    entry.imm = {{51{inst[31]}}, inst[31], inst[7],
                                 inst[30:25], inst[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    entry.fmt = FMT_U;
                    entry.imm = {{32{inst[31]}}, inst[31:12], 12'b0};
                end
                OPC_JAL: begin
                    entry.fmt = FMT_J;
                    entry.imm = {{43{inst[31]}}, inst[31], inst[19:12],
                                 inst[20], inst[30:21], 1'b0};
                end
                default: begin
                    entry.fmt = FMT_NONE;
                    entry.imm = '0;
                end
            endcase
        end

`ifdef IMM_ILLEGAL_CHECK_EN
        // The immediate and format above are still reported for a flagged
        // instruction; the flag only marks the encoding as bad.
        entry.illegal = (inst[1:0] != 2'b11) ||
                        (entry.fmt == FMT_NONE) ||
                        ((entry.fmt == FMT_SH) && (XLEN == 32) && inst[25]) ||
                        ((entry.fmt == FMT_SH) && (funct3 == F3_SRX) &&
                         !((inst[31:26] == 6'b000000) ||
                           (inst[31:26] == 6'b010000)));
`else
        entry.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Immediate generator with a valid/ready input and output. Each accepted
// instruction is decoded by imm_decode and captured into a two-entry buffer
// (main + skid). The output always presents the main entry. With out_ready
// held high the result appears exactly one cycle after acceptance and one
// result per cycle is sustained.
//
// Parameters:
//   XLEN        : datapath width, 32 or 64 only.
//
// Ports:
//   clk         : input         sole clock, rising edge
//   rst_n       : input         asynchronous active-low reset
//   flush       : input         synchronous discard of all buffered entries
//   in_valid    : input         instruction offered
//   in_ready    : output        buffer can take an instruction (registered)
//   in_inst     : input  [31:0] instruction word
//   out_valid   : output        a decoded result is presented
//   out_ready   : input         consumer takes the presented result
//   out_imm     : output [XLEN-1:0] extended immediate
//   out_fmt     : output [2:0]  format code (imm_fmt_e)
//   out_sra     : output        arithmetic shift flag for shift formats
//   out_illegal : output        encoding-error flag
//
// Configuration macro:
//   IMM_ILLEGAL_CHECK_EN : enables the encoding check inside imm_decode;
//                          without it out_illegal is always 0.
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_sra,
    output logic            out_illegal
);

    imm_entry_t dec_entry;
    imm_entry_t main_q;
    imm_entry_t main_d;
    imm_entry_t skid_q;
    imm_entry_t skid_d;
    logic       main_valid_q;
    logic       main_valid_d;
    logic       skid_valid_q;
    logic       skid_valid_d;
    logic       accept;
    logic       pop;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst  (in_inst),
        .entry (dec_entry)
    );

    // in_ready comes straight from the skid flop, so there is no path from
    // out_ready to in_ready. The skid entry absorbs the one instruction that
    // may arrive in the cycle the consumer stalls.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign pop      = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            // Flush wins over everything, including a same-cycle accept.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            if (skid_valid_q) begin
                // Both full: in_ready was low, so nothing is accepted here;
                // the older skid entry moves up to main.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = dec_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = dec_entry;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end
        end
    end

    // Entry payloads are reset too, so the outputs read as an empty NONE
    // entry while nothing valid is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= ENTRY_RESET;
            skid_q       <= ENTRY_RESET;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_fmt     = main_q.fmt;
    assign out_sra     = main_q.sra;
    assign out_illegal = main_q.illegal;

    // On a 32-bit build the top half of the shared entry immediate is never
    // presented; fold it into a deliberately unused net.
    generate
        if (XLEN < IMM_W) begin : g_narrow
            logic unused_imm_hi;
            assign unused_imm_hi = ^main_q.imm[IMM_W-1:XLEN];
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. A 32-bit and a 64-bit instance share the
// same stimulus so both immediate widths are checked from one build.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [31:0] inInst;

    logic        inReady32;
    logic        outValid32;
    logic [31:0] outImm32;
    logic [2:0]  outFmt32;
    logic        outSra32;
    logic        outIllegal32;

    logic        inReady64;
    logic        outValid64;
    logic [63:0] outImm64;
    logic [2:0]  outFmt64;
    logic        outSra64;
    logic        outIllegal64;

    int checkCount = 0;
    int errorCount = 0;

`ifdef IMM_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (inValid),
        .in_ready    (inReady32),
        .in_inst     (inInst),
        .out_valid   (outValid32),
        .out_ready   (outReady),
        .out_imm     (outImm32),
        .out_fmt     (outFmt32),
        .out_sra     (outSra32),
        .out_illegal (outIllegal32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (inValid),
        .in_ready    (inReady64),
        .in_inst     (inInst),
        .out_valid   (outValid64),
        .out_ready   (outReady),
        .out_imm     (outImm64),
        .out_fmt     (outFmt64),
        .out_sra     (outSra64),
        .out_illegal (outIllegal64)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h",
                     tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction (out_ready assumed high) and check the result
    // the cycle after; consecutive calls stream back-to-back.
    task automatic applyStimulus(input logic [31:0] inst,
                                 input logic [31:0] e32Imm, input logic [2:0] e32Fmt,
                                 input logic e32Sra, input logic e32Ill,
                                 input logic [63:0] e64Imm, input logic [2:0] e64Fmt,
                                 input logic e64Sra, input logic e64Ill);
        checkOutput("in_ready_before", {63'b0, inReady32}, 64'd1);
        inInst  = inst;
        inValid = 1'b1;
        tick();
        $display("[TB] inst 0x%08h", inst);
        checkOutput("valid32", {63'b0, outValid32}, 64'd1);
        checkOutput("imm32", {32'b0, outImm32}, {32'b0, e32Imm});
        checkOutput("fmt32", {61'b0, outFmt32}, {61'b0, e32Fmt});
        checkOutput("sra32", {63'b0, outSra32}, {63'b0, e32Sra});
        checkOutput("ill32", {63'b0, outIllegal32}, {63'b0, e32Ill & ILL_EN});
        checkOutput("valid64", {63'b0, outValid64}, 64'd1);
        checkOutput("imm64", outImm64, e64Imm);
        checkOutput("fmt64", {61'b0, outFmt64}, {61'b0, e64Fmt});
        checkOutput("sra64", {63'b0, outSra64}, {63'b0, e64Sra});
        checkOutput("ill64", {63'b0, outIllegal64}, {63'b0, e64Ill & ILL_EN});
    endtask

    localparam logic [31:0] INST_ADDI_M1 = 32'hFFF00093;
    localparam logic [31:0] INST_JAL_M4  = 32'hFFDFF06F;
    localparam logic [31:0] INST_LUI     = 32'h800000B7;

    initial begin
        rst_n    = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        inInst   = 32'h0;

        // Reset: values appear as soon as rst_n falls
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", {63'b0, outValid32}, 64'd0);
        checkOutput("rst_ready", {63'b0, inReady32}, 64'd1);
        checkOutput("rst_imm", {32'b0, outImm32}, 64'd0);
        checkOutput("rst_fmt", {61'b0, outFmt32}, 64'd0);
        checkOutput("rst_sra", {63'b0, outSra32}, 64'd0);
        checkOutput("rst_ill", {63'b0, outIllegal32}, 64'd0);
        checkOutput("rst_imm64", outImm64, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed decode vectors, streamed one per cycle
        applyStimulus(INST_ADDI_M1, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b0,
                      64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 1'b0);
        applyStimulus(32'h4030D093, 32'h00000003, 3'd6, 1'b1, 1'b0,
                      64'h3, 3'd6, 1'b1, 1'b0);
        applyStimulus(INST_JAL_M4, 32'hFFFFFFFC, 3'd5, 1'b0, 1'b0,
                      64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0, 1'b0);
        applyStimulus(INST_LUI, 32'h80000000, 3'd4, 1'b0, 1'b0,
                      64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b0);
        applyStimulus(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 1'b0,
                      64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 1'b0);
        applyStimulus(32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 1'b0,
                      64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0, 1'b0);
        applyStimulus(32'h00000863, 32'h00000010, 3'd3, 1'b0, 1'b0,
                      64'h10, 3'd3, 1'b0, 1'b0);
        applyStimulus(32'h02109093, 32'h00000001, 3'd6, 1'b0, 1'b1,
                      64'h21, 3'd6, 1'b0, 1'b0);
        applyStimulus(32'h00000000, 32'h00000000, 3'd0, 1'b0, 1'b1,
                      64'h0, 3'd0, 1'b0, 1'b1);
        applyStimulus(32'hFFF0009B, 32'h00000000, 3'd0, 1'b0, 1'b1,
                      64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 1'b0);
        applyStimulus(32'h7FF02083, 32'h000007FF, 3'd1, 1'b0, 1'b0,
                      64'h7FF, 3'd1, 1'b0, 1'b0);
        applyStimulus(32'h12345097, 32'h12345000, 3'd4, 1'b0, 1'b0,
                      64'h12345000, 3'd4, 1'b0, 1'b0);
        applyStimulus(32'h2030D093, 32'h00000003, 3'd6, 1'b0, 1'b1,
                      64'h3, 3'd6, 1'b0, 1'b1);
        applyStimulus(32'h4230D093, 32'h00000003, 3'd6, 1'b1, 1'b1,
                      64'h23, 3'd6, 1'b1, 1'b0);
        inValid = 1'b0;
        tick();
        checkOutput("drain_valid", {63'b0, outValid32}, 64'd0);

        // Back-pressure: three offers with out_ready low, two accepted
        outReady = 1'b0;
        inValid  = 1'b1;
        inInst   = INST_ADDI_M1;
        tick();
        checkOutput("bp_valid_a", {63'b0, outValid32}, 64'd1);
        checkOutput("bp_imm_a", {32'b0, outImm32}, 64'hFFFFFFFF);
        checkOutput("bp_ready_1", {63'b0, inReady32}, 64'd1);
        inInst = INST_JAL_M4;
        tick();
        checkOutput("bp_hold_a1", {32'b0, outImm32}, 64'hFFFFFFFF);
        checkOutput("bp_ready_full", {63'b0, inReady32}, 64'd0);
        inInst = INST_LUI;
        tick();
        checkOutput("bp_hold_a2", {32'b0, outImm32}, 64'hFFFFFFFF);
        checkOutput("bp_hold_fmt", {61'b0, outFmt32}, 64'd1);
        checkOutput("bp_ready_still", {63'b0, inReady32}, 64'd0);
        outReady = 1'b1;
        tick();
        checkOutput("bp_out_b", {32'b0, outImm32}, 64'hFFFFFFFC);
        checkOutput("bp_fmt_b", {61'b0, outFmt32}, 64'd5);
        checkOutput("bp_ready_back", {63'b0, inReady32}, 64'd1);
        tick();
        checkOutput("bp_valid_c", {63'b0, outValid32}, 64'd1);
        checkOutput("bp_out_c", {32'b0, outImm32}, 64'h80000000);
        inValid = 1'b0;
        tick();
        checkOutput("bp_empty", {63'b0, outValid32}, 64'd0);

        // Flush with both entries full and in_valid high
        outReady = 1'b0;
        inValid  = 1'b1;
        inInst   = INST_ADDI_M1;
        tick();
        inInst = INST_JAL_M4;
        tick();
        checkOutput("fl_full", {63'b0, inReady32}, 64'd0);
        flush  = 1'b1;
        inInst = INST_LUI;
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        checkOutput("fl_valid", {63'b0, outValid32}, 64'd0);
        checkOutput("fl_ready", {63'b0, inReady32}, 64'd1);
        tick();
        checkOutput("fl_stay_empty", {63'b0, outValid32}, 64'd0);

        // Flush discards an accept that would otherwise have happened
        inValid = 1'b1;
        inInst  = INST_ADDI_M1;
        tick();
        flush  = 1'b1;
        inInst = INST_LUI;
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        checkOutput("fl2_valid", {63'b0, outValid32}, 64'd0);
        checkOutput("fl2_ready", {63'b0, inReady32}, 64'd1);
        tick();
        checkOutput("fl2_dropped", {63'b0, outValid32}, 64'd0);

        // Reset asserted with both entries held
        inValid = 1'b1;
        inInst  = INST_ADDI_M1;
        tick();
        inInst = INST_JAL_M4;
        tick();
        inValid = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkOutput("mr_valid", {63'b0, outValid32}, 64'd0);
        checkOutput("mr_ready", {63'b0, inReady32}, 64'd1);
        checkOutput("mr_imm", {32'b0, outImm32}, 64'd0);
        checkOutput("mr_valid64", {63'b0, outValid64}, 64'd0);
        tick();
        rst_n    = 1'b1;
        outReady = 1'b1;
        tick();
        tick();
        checkOutput("mr_no_output", {63'b0, outValid32}, 64'd0);
        applyStimulus(INST_LUI, 32'h80000000, 3'd4, 1'b0, 1'b0,
                      64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b0);
        inValid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
